// File: rtl/igs_butterfly_pkg.sv
// Shared definitions for the inverse (Gentleman-Sande) NTT butterfly:
// FSM encoding, default field parameters and the fixed start-to-done latency.
package igs_butterfly_pkg;

    localparam int unsigned DEF_WIDTH = 25;
    localparam int unsigned DEF_Q     = 17;
    localparam int unsigned DEF_W_INV = 9;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_TWGEN = 3'd2;
    localparam logic [2:0] S_MULT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    // Twiddle exponent is scanned over 5 bits; each bit costs a square and a multiply.
    localparam int unsigned TW_ITERS = 5;
    localparam int unsigned TW_MULS  = 2 * TW_ITERS;

    function automatic int unsigned latency_cycles(input int unsigned width);
        return 11 * width + 2;
    endfunction

    localparam int unsigned DEF_LATENCY = 11 * DEF_WIDTH + 2;

endpackage

// File: rtl/mod_mul_seq.sv
// Bit-serial modular multiplier: p = a*b mod Q in exactly n clocks, MSB of b first.
module mod_mul_seq #(
    parameter int unsigned n = 25,
    parameter int unsigned Q = 17
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         go,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] p,
    output logic         rdy
);

    localparam int unsigned CNT_W = $clog2(n + 1);
    localparam logic [n:0]  QX    = (n+1)'(Q);

    logic [n-1:0]     a_q, a_d;
    logic [n-1:0]     b_q, b_d;
    logic [n-1:0]     p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             rdy_q, rdy_d;

    // One shift-add step with reduction after the doubling and after the add.
    function automatic logic [n-1:0] mm_step(input logic [n-1:0] acc,
                                             input logic [n-1:0] mcand,
                                             input logic         sel);
        logic [n:0] t;
        t = {acc, 1'b0};
        if (t >= QX) t = t - QX;
        if (sel) begin
            t = t + {1'b0, mcand};
            if (t >= QX) t = t - QX;
        end
        return t[n-1:0];
    endfunction

    // The go edge performs the first step so back-to-back multiplies stay n cycles apart.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        p_d   = p_q;
        cnt_d = cnt_q;
        run_d = run_q;
        rdy_d = 1'b0;
        if (go) begin
            a_d   = a;
            b_d   = b << 1;
            p_d   = mm_step('0, a, b[n-1]);
            cnt_d = CNT_W'(n - 1);
            run_d = (n > 1);
            rdy_d = (n == 1);
        end else if (run_q) begin
            b_d   = b_q << 1;
            p_d   = mm_step(p_q, a_q, b_q[n-1]);
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                run_d = 1'b0;
                rdy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            p_q   <= p_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            rdy_q <= rdy_d;
        end
    end

    assign p   = p_q;
    assign rdy = rdy_q;

endmodule

// File: rtl/igs_butterfly.sv
// Inverse NTT butterfly: x1 = h(u+v), x2 = h((u-v)*W_INV^e), twiddle generated by
// square-and-multiply on one shared sequential multiplier, fixed 11n+2 latency.
module igs_butterfly
    import igs_butterfly_pkg::*;
#(
    parameter int unsigned n     = DEF_WIDTH,
    parameter int unsigned Q     = DEF_Q,
    parameter int unsigned W_INV = DEF_W_INV,
    parameter bit          SCALE = 1'b1
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic [4:0]   i,
    input  logic [4:0]   j,
    input  logic [4:0]   N,
    input  logic         start,
    input  logic [n-1:0] u_inp,
    input  logic [n-1:0] v_inp,
    output logic [n-1:0] x1_out,
    output logic [n-1:0] x2_out,
    output logic [n-1:0] tw_out,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CYC_W = $clog2(TW_MULS * n);
    localparam logic [n:0]  QX    = (n+1)'(Q);

    logic [2:0]       state_q, state_d;
    logic [4:0]       i_q, i_d, j_q, j_d, nl_q, nl_d, e_q, e_d;
    logic [n-1:0]     u_q, u_d, v_q, v_d;
    logic [n-1:0]     acc_q, acc_d, s_q, s_d, d_q, d_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [3:0]       idx_q, idx_d;
    logic [n-1:0]     x1_q, x1_d, x2_q, x2_d, tw_q, tw_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             go_c;
    logic [n-1:0]     ma_c, mb_c;
    logic [n-1:0]     mul_p;
    logic             mul_rdy;
    logic [n:0]       sum_c, diff_c;

    // Optional halving by 2^-1 mod Q: odd values are lifted by Q first.
    function automatic logic [n-1:0] halve(input logic [n-1:0] a);
        logic [n:0] t;
        t = a[0] ? ({1'b0, a} + QX) : {1'b0, a};
        return SCALE ? n'(t >> 1) : a;
    endfunction

    mod_mul_seq #(
        .n (n),
        .Q (Q)
    ) u_mul (
        .clock (clock),
        .rst_n (rst_n),
        .go    (go_c),
        .a     (ma_c),
        .b     (mb_c),
        .p     (mul_p),
        .rdy   (mul_rdy)
    );

    // Modular sum and difference with a single correction each.
    always_comb begin
        sum_c = {1'b0, u_q} + {1'b0, v_q};
        if (sum_c >= QX) sum_c = sum_c - QX;
        diff_c = {1'b0, u_q} - {1'b0, v_q};
        if (diff_c[n]) diff_c = diff_c + QX;
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        nl_d    = nl_q;
        u_d     = u_q;
        v_d     = v_q;
        e_d     = e_q;
        acc_d   = acc_q;
        s_d     = s_q;
        d_d     = d_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        tw_d    = tw_q;
        done_d  = 1'b0;
        go_c    = 1'b0;
        ma_c    = '0;
        mb_c    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    i_d     = i;
                    j_d     = j;
                    nl_d    = N;
                    u_d     = u_inp;
                    v_d     = v_inp;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                e_d     = 5'(j_q << i_q) & (nl_q - 5'd1);
                acc_d   = n'(1);
                s_d     = sum_c[n-1:0];
                d_d     = diff_c[n-1:0];
                cyc_d   = CYC_W'(TW_MULS * n - 1);
                idx_d   = '0;
                state_d = S_TWGEN;
            end

            S_TWGEN, S_MULT: begin
                // idx counts issued multiplies; odd idx means a square just finished.
                if (idx_q == '0) begin
                    go_c  = 1'b1;
                    ma_c  = acc_q;
                    mb_c  = acc_q;
                    idx_d = 4'd1;
                end else if (mul_rdy && idx_q <= 4'd10) begin
                    go_c  = 1'b1;
                    idx_d = idx_q + 4'd1;
                    if (idx_q[0]) begin
                        acc_d = mul_p;
                        ma_c  = mul_p;
                        mb_c  = n'(W_INV);
                    end else begin
                        acc_d = e_q[4] ? mul_p : acc_q;
                        e_d   = e_q << 1;
                        ma_c  = (idx_q == 4'd10) ? d_q : acc_d;
                        mb_c  = acc_d;
                    end
                end

                if (cyc_q == '0) begin
                    if (state_q == S_TWGEN) begin
                        state_d = S_MULT;
                        cyc_d   = CYC_W'(n - 1);
                    end else begin
                        state_d = S_OUT;
                    end
                end else begin
                    cyc_d = cyc_q - CYC_W'(1);
                end
            end

            S_OUT: begin
                x1_d    = halve(s_q);
                x2_d    = halve(mul_p);
                tw_d    = acc_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            nl_q    <= '0;
            u_q     <= '0;
            v_q     <= '0;
            e_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            d_q     <= '0;
            cyc_q   <= '0;
            idx_q   <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            tw_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            nl_q    <= nl_d;
            u_q     <= u_d;
            v_q     <= v_d;
            e_q     <= e_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            d_q     <= d_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            tw_q    <= tw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x1_out = x1_q;
    assign x2_out = x2_q;
    assign tw_out = tw_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_igs_butterfly.sv
// Randomized bench for igs_butterfly against a plain-arithmetic model (Q=17, W_INV=9, n=25).
module tb_igs_butterfly;

    localparam int unsigned NW  = 25;
    localparam int          QM  = 17;
    localparam int          WI  = 9;
    localparam int          LAT = 277;
    localparam int          WIN = LAT + 6;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    i_s, j_s, n_s;
    logic          start;
    logic [NW-1:0] u_s, v_s;
    logic [NW-1:0] x1, x2, tw, x1n, x2n, twn;
    logic          busy, done, busyn, donen;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    int op_id   = 0;
    int last_x1, last_x2, last_tw;

    igs_butterfly #(.n(NW), .Q(QM), .W_INV(WI), .SCALE(1'b1)) dut (
        .clock (clk), .rst_n (rst_n), .i (i_s), .j (j_s), .N (n_s), .start (start),
        .u_inp (u_s), .v_inp (v_s), .x1_out (x1), .x2_out (x2), .tw_out (tw),
        .busy (busy), .done (done)
    );

    igs_butterfly #(.n(NW), .Q(QM), .W_INV(WI), .SCALE(1'b0)) dut_ns (
        .clock (clk), .rst_n (rst_n), .i (i_s), .j (j_s), .N (n_s), .start (start),
        .u_inp (u_s), .v_inp (v_s), .x1_out (x1n), .x2_out (x2n), .tw_out (twn),
        .busy (busyn), .done (donen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL op%0d %s: got %0d expected %0d", op_id, tag, got, exp);
        end
    endtask

    // Reference: W_INV^e mod Q by repeated multiplication.
    function automatic int tw_ref(input int ii, input int jj, input int nn);
        int e;
        int t;
        e = ((jj << ii) & (nn - 1)) & 31;
        t = 1;
        for (int k = 0; k < e; k++) t = (t * WI) % QM;
        return t;
    endfunction

    function automatic int half_ref(input int a);
        return (a % 2 == 0) ? a / 2 : (a + QM) / 2;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, " x1"}, 32'(x1), 0);
        chk({tag, " x2"}, 32'(x2), 0);
        chk({tag, " tw"}, 32'(tw), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " ns x1"}, 32'(x1n), 0);
        chk({tag, " ns busy"}, 32'(busyn), 0);
        chk({tag, " ns done"}, 32'(donen), 0);
    endtask

    task automatic run_op(input int ti, input int tj, input int tn, input int tu, input int tv,
                          input int repulse_at, input bit hold);
        int   etw, s, d, px, lat, dones, dones_n, done_c, t0;
        bit   idle_ok;
        logic b_load, b_after;
        etw = tw_ref(ti, tj, tn);
        s   = (tu + tv) % QM;
        d   = (tu - tv + QM) % QM;
        px  = (d * etw) % QM;
        lat = -1; dones = 0; dones_n = 0; done_c = -10; b_load = 1'b0; b_after = 1'b0;
        op_id++;
        @(negedge clk);
        i_s = 5'(ti); j_s = 5'(tj); n_s = 5'(tn); u_s = NW'(tu); v_s = NW'(tv);
        start = 1'b1;
        t0 = cyc + 1;
        for (int c = 0; c < WIN; c++) begin
            @(negedge clk);
            if (c == 0) begin
                b_load = busy;
                if (!hold) start = 1'b0;
            end
            if (c == repulse_at) begin
                start = 1'b1;
                u_s = NW'($urandom_range(0, QM - 1));
                v_s = NW'($urandom_range(0, QM - 1));
            end else if (c == repulse_at + 1 && !hold) begin
                start = 1'b0;
            end
            if (c == done_c + 1) b_after = busy;
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = cyc - t0;
                    done_c = c;
                end
            end
            if (donen) dones_n++;
        end
        chk("latency", 32'(lat), 32'(LAT));
        chk("done count", 32'(dones), 1);
        chk("ns done count", 32'(dones_n), 1);
        chk("busy in load", 32'(b_load), 1);
        chk("busy after done", 32'(b_after), 32'(hold));
        chk("x1", 32'(x1), 32'(half_ref(s)));
        chk("x2", 32'(x2), 32'(half_ref(px)));
        chk("tw", 32'(tw), 32'(etw));
        chk("ns x1", 32'(x1n), 32'(s));
        chk("ns x2", 32'(x2n), 32'(px));
        chk("ns tw", 32'(twn), 32'(etw));
        last_x1 = half_ref(s); last_x2 = half_ref(px); last_tw = etw;
        if (hold) begin
            start = 1'b0;
            idle_ok = 1'b0;
            for (int c = 0; c < 2 * WIN && !idle_ok; c++) begin
                @(negedge clk);
                if (!busy) idle_ok = 1'b1;
            end
            chk("restart completes", 32'(idle_ok), 1);
        end
    endtask

    task automatic reset_mid(input int at);
        int dn;
        int bz;
        dn = 0; bz = 0;
        op_id++;
        @(negedge clk);
        i_s = 5'd1; j_s = 5'd1; n_s = 5'd8; u_s = NW'(5); v_s = NW'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (at - 1) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("mid reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < WIN; c++) begin
            @(negedge clk);
            if (done || donen) dn++;
            if (busy || busyn) bz++;
        end
        chk("no done after reset", 32'(dn), 0);
        chk("no busy after reset", 32'(bz), 0);
    endtask

    initial begin
        start = 1'b0;
        i_s = '0; j_s = '0; n_s = '0; u_s = '0; v_s = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        run_op(1, 1, 8, 5, 3, -1, 1'b0);
        run_op(1, 1, 8, 3, 5, -1, 1'b0);
        run_op(0, 0, 8, 16, 16, -1, 1'b0);
        run_op(1, 1, 8, 5, 3, 50, 1'b0);
        run_op(2, 3, 16, 16, 15, -1, 1'b0);
        run_op(1, 3, 8, 7, 2, -1, 1'b1);
        reset_mid(100);
        run_op(1, 1, 8, 5, 3, -1, 1'b0);

        for (int k = 0; k < 20; k++) begin
            int rp;
            rp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, LAT - 10)) : -1;
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                   1 << $urandom_range(1, 4),
                   int'($urandom_range(0, QM - 1)), int'($urandom_range(0, QM - 1)),
                   rp, 1'b0);
        end

        repeat (25) @(negedge clk);
        chk("hold x1", 32'(x1), 32'(last_x1));
        chk("hold x2", 32'(x2), 32'(last_x2));
        chk("hold tw", 32'(tw), 32'(last_tw));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
